// File: rtl/id_ex_stage_if.sv
// Bus between ID, the forwarding sources (EX/MEM, MEM/WB) and the ID/EX stage.
// The stage takes the slave side; the surrounding pipeline drives the master side.
interface id_ex_stage_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4
);
  logic             flush;
  logic             id_valid;
  logic [2:0]       id_op;
  logic [ASIZE-1:0] id_rs1;
  logic [ASIZE-1:0] id_rs2;
  logic [ASIZE-1:0] id_rd;
  logic [DSIZE-1:0] id_rdata1;
  logic [DSIZE-1:0] id_rdata2;
  logic [DSIZE-1:0] id_imm;
  logic             id_use_imm;
  logic             id_wen;
  logic             id_memrd;
  logic             id_memwr;
  logic             id_branch;

  logic [ASIZE-1:0] exmem_rd;
  logic             exmem_wen;
  logic             exmem_memrd;
  logic [DSIZE-1:0] exmem_result;
  logic [ASIZE-1:0] memwb_rd;
  logic             memwb_wen;
  logic [DSIZE-1:0] memwb_result;

  logic             stall;
  logic             ex_valid;
  logic             ex_wen;
  logic             ex_memrd;
  logic             ex_memwr;
  logic             ex_branch;
  logic [2:0]       ex_op;
  logic [ASIZE-1:0] ex_rd;
  logic [DSIZE-1:0] ex_a;
  logic [DSIZE-1:0] ex_b;
  logic [DSIZE-1:0] ex_store_data;

  modport master (
    output flush, id_valid, id_op, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2,
           id_imm, id_use_imm, id_wen, id_memrd, id_memwr, id_branch,
           exmem_rd, exmem_wen, exmem_memrd, exmem_result,
           memwb_rd, memwb_wen, memwb_result,
    input  stall, ex_valid, ex_wen, ex_memrd, ex_memwr, ex_branch, ex_op, ex_rd,
           ex_a, ex_b, ex_store_data
  );

  modport slave (
    input  flush, id_valid, id_op, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2,
           id_imm, id_use_imm, id_wen, id_memrd, id_memwr, id_branch,
           exmem_rd, exmem_wen, exmem_memrd, exmem_result,
           memwb_rd, memwb_wen, memwb_result,
    output stall, ex_valid, ex_wen, ex_memrd, ex_memwr, ex_branch, ex_op, ex_rd,
           ex_a, ex_b, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection (stall toward IF/ID plus bubble insertion).
module id_ex_stage #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [ASIZE-1:0] rs1;
    logic [ASIZE-1:0] rs2;
    logic [ASIZE-1:0] rd;
    logic [DSIZE-1:0] rdata1;
    logic [DSIZE-1:0] rdata2;
    logic [DSIZE-1:0] imm;
    logic             use_imm;
    logic             wen;
    logic             memrd;
    logic             memwr;
    logic             branch;
  } stage_t;

  stage_t           stage_q, stage_d;
  logic             load_use;
  logic             exmem_fwd_ok, memwb_fwd_ok;
  logic [DSIZE-1:0] fwd1, fwd2;

  // Only the rs2 comparison is exempted for immediates: a store still needs rs2 as data.
  always_comb begin
    load_use = bus.id_valid && stage_q.valid && stage_q.memrd && (stage_q.rd != '0) &&
               ((stage_q.rd == bus.id_rs1) ||
                ((stage_q.rd == bus.id_rs2) && (!bus.id_use_imm || bus.id_memwr)));
  end

  always_comb begin
    // NOTE: default first so every path assigns stage_d; no latch can be inferred.
    stage_d = '0;
    if (!bus.flush && !load_use) begin
      stage_d.valid   = bus.id_valid;
      stage_d.op      = bus.id_op;
      stage_d.rs1     = bus.id_rs1;
      stage_d.rs2     = bus.id_rs2;
      stage_d.rd      = bus.id_rd;
      stage_d.rdata1  = bus.id_rdata1;
      stage_d.rdata2  = bus.id_rdata2;
      stage_d.imm     = bus.id_imm;
      stage_d.use_imm = bus.id_use_imm;
      stage_d.wen     = bus.id_wen    & bus.id_valid;
      stage_d.memrd   = bus.id_memrd  & bus.id_valid;
      stage_d.memwr   = bus.id_memwr  & bus.id_valid;
      stage_d.branch  = bus.id_branch & bus.id_valid;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stage_q <= '0;
    else      stage_q <= stage_d;
  end

  // A load sitting in EX/MEM has no data yet; the load-use stall covers that case.
  assign exmem_fwd_ok = bus.exmem_wen && !bus.exmem_memrd && (bus.exmem_rd != '0);
  assign memwb_fwd_ok = bus.memwb_wen && (bus.memwb_rd != '0);

  always_comb begin
    fwd1 = stage_q.rdata1;
    if (exmem_fwd_ok && (bus.exmem_rd == stage_q.rs1))      fwd1 = bus.exmem_result;
    else if (memwb_fwd_ok && (bus.memwb_rd == stage_q.rs1)) fwd1 = bus.memwb_result;

    fwd2 = stage_q.rdata2;
    if (exmem_fwd_ok && (bus.exmem_rd == stage_q.rs2))      fwd2 = bus.exmem_result;
    else if (memwb_fwd_ok && (bus.memwb_rd == stage_q.rs2)) fwd2 = bus.memwb_result;
  end

  assign bus.stall         = load_use;
  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_op         = stage_q.op;
  assign bus.ex_rd         = stage_q.rd;
  assign bus.ex_wen        = stage_q.wen;
  assign bus.ex_memrd      = stage_q.memrd;
  assign bus.ex_memwr      = stage_q.memwr;
  assign bus.ex_branch     = stage_q.branch;
  assign bus.ex_a          = fwd1;
  assign bus.ex_b          = stage_q.use_imm ? stage_q.imm : fwd2;
  assign bus.ex_store_data = fwd2;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the five-stage CPU.
- Captures decoded operands and control from ID and drives the EX-stage ALU operands and opcode.
- Forwards results from EX/MEM and MEM/WB to resolve RAW hazards.
- Detects load-use hazards, raising a stall toward IF/ID and inserting a bubble.

Parameters:
- DSIZE, 16, datapath width.
- ASIZE, 4, register-address width. r0 reads as zero and is never forwarded.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- flush  in  1  branch-taken squash from branch resolution
- id_valid  in  1  ID holds a real instruction
- id_op  in  3  ALU opcode (ADD/SUB/AND/XOR/COM/MUL/ADDI encodings)
- id_rs1, id_rs2, id_rd  in  ASIZE  source and destination register numbers
- id_rdata1, id_rdata2  in  DSIZE  register-file read data
- id_imm  in  DSIZE  sign-extended immediate
- id_use_imm  in  1  B operand is the immediate
- id_wen, id_memrd, id_memwr, id_branch  in  1  control bits
- exmem_rd  in  ASIZE  destination register in EX/MEM
- exmem_wen, exmem_memrd  in  1  EX/MEM control bits
- exmem_result  in  DSIZE  EX/MEM ALU result
- memwb_rd  in  ASIZE  destination register in MEM/WB
- memwb_wen  in  1  MEM/WB write enable
- memwb_result  in  DSIZE  MEM/WB write-back value
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid, ex_wen, ex_memrd, ex_memwr, ex_branch  out  1  registered control
- ex_op  out  3  registered opcode to ALU
- ex_rd  out  ASIZE  registered destination register
- ex_a, ex_b  out  DSIZE  forwarded ALU operands (combinational from registers)
- ex_store_data  out  DSIZE  forwarded rs2 value for stores

Behaviour:
- Reset: all registered fields clear to 0 asynchronously. Outputs after reset: ex_valid=0, all control=0, ex_op=0, ex_rd=0, ex_a=ex_b=ex_store_data=0. Reset mid-operation discards the held instruction with no partial state.
- Load-use stall: stall=1 when all of the following hold:
  - id_valid & ex_valid & ex_memrd & ex_rd!=0
  - and either ex_rd==id_rs1, or ex_rd==id_rs2 with (!id_use_imm | id_memwr).
  - Otherwise stall=0.
- Register update each rising edge, in priority order:
  1. flush=1: load a bubble. valid, wen, memrd, memwr and branch are 0; rd=0; other fields don't-care but cleared to 0. Flush beats stall.
  2. stall=1: load a bubble as above. ID contents are held upstream and re-presented next cycle.
  3. Otherwise: capture all id_* fields. Control bits are ANDed with id_valid.
- Forwarding for operand A, selected from registered rs1 / rdata1:
  - EX/MEM hit: exmem_wen & !exmem_memrd & exmem_rd!=0 & exmem_rd==rs1 → use exmem_result.
  - Else MEM/WB hit: memwb_wen & memwb_rd!=0 & memwb_rd==rs1 → use memwb_result.
  - Else use the registered rdata1.
  - EX/MEM has priority over MEM/WB (newest value wins).
- Forwarding for operand B: the same selection on rs2 gives fwd2.
  - ex_store_data = fwd2.
  - ex_b = imm if use_imm, else fwd2.
- Load in EX/MEM: never forwarded from EX/MEM. The stall guarantees it reaches MEM/WB before the consumer sits in EX.
- Forwarding is combinational on the registered state. It adds no extra latency; the stage latency is 1 cycle.
- Same-cycle write-back to a register being read in ID is handled by the register file (write-first), not by this block.
- A bubble (ex_valid=0) still drives ex_op=0 and zeroed control, so the downstream ALU output is ignored by writeback.

Test Plan:
- Reset: assert rst=0 mid-stream holding a valid ADD → ex_valid=0, ex_a=ex_b=0 immediately, independent of clk. Release and issue ADD r1=r2+r3 with rdata 5, 7 → next cycle ex_a=5, ex_b=7, ex_op=ADD, ex_valid=1.
- EX/MEM forwarding: exmem_rd=2, exmem_wen=1, exmem_result=0x00AA, registered rs1=2, rdata1=0x0011 → ex_a=0x00AA. Set exmem_rd=0 with the same values → ex_a=0x0011.
- Priority: exmem and memwb both target r3 with results 0x0100 and 0x0200, rs2=3, use_imm=0 → ex_b=0x0100. Set exmem_wen=0 → ex_b=0x0200.
- Load-use: EX holds load r4 (memrd=1, rd=4), ID presents SUB using rs1=4 → stall=1, next cycle ex_valid=0 with ex_wen=0. The following cycle stall=0, SUB is captured, and ex_a=memwb_result when memwb_rd=4.
- Immediate exemption: ID holds ADDI with rs2=4, use_imm=1, memwr=0, against a load to r4 → stall=0. Same with memwr=1 (store data) → stall=1.
- Flush vs stall: flush=1 and stall=1 in the same cycle → bubble captured (ex_valid=0). Flush with a valid ID instruction → ex_wen=ex_memwr=ex_branch=0.
